jk_sync_counter: RTL and testbench
==================================

# jk_sync_counter

Modulo-N synchronous up/down counter built from a bank of JK storage cells, with all next-state excitation generated in front of them. It is the excitation stage directly upstream of the JK flip-flop: it computes a J/K pair per bit from the current count and the control inputs, and feeds those pairs to its own cells. The per-bit J/K pairs are also exported so benches can check them against the JK truth table.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 10: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  count enable.
- up  in  1  direction: 1 counts up, 0 counts down.
- load  in  1  synchronous load of din.
- din  in  WIDTH  load value.
- q  out  WIDTH  current count.
- j  out  WIDTH  per-bit J excitation; combinational.
- k  out  WIDTH  per-bit K excitation; combinational.
- tc  out  1  terminal count; combinational.
- wrap  out  1  one-cycle pulse after a wrap-around; registered.

## Operation
- Reset: rst=0 forces q=0 and wrap=0 immediately, without waiting for clk.
- Next-state value n is selected by priority:
  - load=1: n = din, clamped to MODULUS-1 when din ≥ MODULUS.
  - else en=1, up=1: n = (q==MODULUS-1) ? 0 : q+1.
  - else en=1, up=0: n = (q==0) ? MODULUS-1 : q-1.
  - else: n = q.
- Excitation per bit i: j[i] = ~q[i] & n[i]; k[i] = q[i] & ~n[i].
  - The minimal form never issues the toggle code (11). Bits that do not change get 00 (hold).
- JK cell behaviour: 00 hold, 01 clear, 10 set, 11 toggle. Each cell has the async active-low reset to 0.
- tc = en & ~load & (up ? q==MODULUS-1 : q==0).
- wrap is set for exactly one cycle following any edge at which the counter wrapped, i.e. an edge taken while tc=1. It is 0 otherwise.
- Boundary cases:
  - load with tc=1: load wins, no wrap.
  - up toggled mid-count: takes effect on the next edge.
  - Arithmetic is WIDTH bits with no carry-out. MODULUS=2**WIDTH gives natural binary wrap.

## Timing
- Latency: q reflects n one clk edge after the inputs are sampled.
- j, k and tc are valid in the same cycle as the inputs that produce them, so they must settle before the next edge.
- Asynchronous assertion of rst clears q and wrap at once.
- The first count or load edge is the first rising edge after rst returns to 1.
- If rst asserts mid-operation, any pending wrap is discarded.
- Reset values: q=0, wrap=0. j, k and tc follow the inputs: with en=0 and load=0 they are all 0.
- Sustained counting gives one wrap pulse every MODULUS cycles.

## Structure
- Package jk_pkg holds:
  - The JK mode encodings: JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
  - A next-bit function that maps (q, j, k) to the next q.
- Sub-module jk_cell: a single-bit JK flip-flop with clk and active-low async rst, instanced WIDTH times via generate.
- Excitation logic, tc and the wrap register live in jk_sync_counter.

## Test plan
All scenarios use WIDTH=4, MODULUS=10.
- Async reset: count to q=7, drive rst=0 between clock edges. q=0 and wrap=0 before the next edge; q stays 0 while rst=0.
- Up wrap: from q=0 with en=1, up=1:
  - After 9 edges q=9 and tc=1.
  - The 10th edge gives q=0, with wrap=1 for exactly one cycle.
  - After 20 edges, exactly 2 wrap pulses have been seen.
- Down wrap: from q=0 with en=1, up=0. The next edge gives q=9 and wrap=1. Further edges give 8, 7, ....
- Load and clamp:
  - din=5, load=1, en=1 → q=5, no wrap.
  - din=12, load=1 → q=9.
  - At q=9 with up=1, load=1, din=3 → q=3, wrap stays 0.
- Hold: at q=6 with en=0 for 5 cycles → q stays 6, j=4'b0000, k=4'b0000, tc=0.
- Excitation check:
  - q=7, en=1, up=1 → j=4'b1000, k=4'b0111, then q=8.
  - q=8, up=0 → j=4'b0111, k=4'b1000, then q=7.

Source files
------------

// File: rtl/jk_pkg.sv
// ---------------------------------------------------------------------------
// jk_pkg
// Shared definitions for the JK-cell based synchronous counter.
//   - JK_* : 2-bit {J,K} mode encodings (hold / clear / set / toggle)
//   - jk_next() : next value of a single JK storage bit given (q, j, k)
// ---------------------------------------------------------------------------
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Classic JK characteristic equation, written as a mode decode.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic r_nxt;
        case ({j, k})
            JK_HOLD: r_nxt = q;
            JK_CLR:  r_nxt = 1'b0;
            JK_SET:  r_nxt = 1'b1;
            JK_TGL:  r_nxt = ~q;
            default: r_nxt = q;
        endcase
        return r_nxt;
    endfunction

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// Single-bit JK flip-flop, rising-edge clocked, asynchronous active-low reset.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-low (clears the bit)
//   i_j  : J input
//   i_k  : K input
//   o_q  : stored bit
// ---------------------------------------------------------------------------
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    // JK storage bit: async clear, otherwise follow the JK characteristic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= jk_next(r_q, i_j, i_k);
        end
    end

    assign o_q = r_q;

endmodule : jk_cell

// File: rtl/jk_sync_counter.sv
// ---------------------------------------------------------------------------
// jk_sync_counter
// Modulo-MODULUS synchronous up/down counter built from WIDTH JK cells. The
// next count is computed first, then turned into per-bit J/K excitation
// (minimal form: set, clear or hold only) which drives the cells.
// Parameters:
//   WIDTH   : counter width in bits
//   MODULUS : count range 0..MODULUS-1 (2..2**WIDTH)
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low (q=0, wrap=0)
//   en   : count enable
//   up   : direction, 1 = up, 0 = down
//   load : synchronous load of din (highest priority, clamped to MODULUS-1)
//   din  : load value
//   q    : current count
//   j, k : per-bit excitation, combinational
//   tc   : terminal count, combinational
//   wrap : one-cycle pulse after a wrap-around edge, registered
// ---------------------------------------------------------------------------
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    // One extra bit so MODULUS = 2**WIDTH is representable in the clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_tc;
    logic             r_wrap;

    // Next-count selection: load > count up > count down > hold.
    always_comb begin
        w_next = w_q;
        if (load) begin
            if ({1'b0, din} >= MOD_EXT) begin
                w_next = LAST;
            end else begin
                w_next = din;
            end
        end else if (en) begin
            if (up) begin
                w_next = (w_q == LAST) ? ZERO : (w_q + ONE);
            end else begin
                w_next = (w_q == ZERO) ? LAST : (w_q - ONE);
            end
        end else begin
            w_next = w_q;
        end
    end

    // Minimal excitation: set bits rising 0->1, clear bits falling 1->0.
    assign w_j = ~w_q &  w_next;
    assign w_k =  w_q & ~w_next;

    // Terminal count: the next enabled, non-load edge wraps the counter.
    always_comb begin
        w_tc = 1'b0;
        if (en && !load) begin
            w_tc = up ? (w_q == LAST) : (w_q == ZERO);
        end else begin
            w_tc = 1'b0;
        end
    end

    // Bank of JK storage cells holding the count.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .i_j (w_j[g]),
            .i_k (w_k[g]),
            .o_q (w_q[g])
        );
    end

    // Wrap pulse: an edge taken with tc high is exactly a wrap-around edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tc;
        end
    end

    assign q    = w_q;
    assign j    = w_j;
    assign k    = w_k;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule : jk_sync_counter

// File: tb/tb_jk_sync_counter.sv
// ---------------------------------------------------------------------------
// tb_jk_sync_counter
// Self-checking bench for jk_sync_counter (WIDTH=4, MODULUS=10). Each driven
// cycle pushes the expected post-edge state onto a scoreboard queue; the
// scenario tasks pop and compare after the edge.
// ---------------------------------------------------------------------------
module tb_jk_sync_counter;

    localparam int W = 4;
    localparam int M = 10;

    typedef struct {
        logic [W-1:0] q;
        logic         wrap;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic         tc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         tc;
    logic         wrap;

    exp_t         sb[$];
    int           vectors;
    int           miscompares;
    logic [W-1:0] m_q;
    logic [W-1:0] obs_j;
    logic [W-1:0] obs_k;
    logic         obs_tc;

    jk_sync_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .j    (j),
        .k    (k),
        .tc   (tc),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference count model using plain integer modulo arithmetic.
    function automatic int model_next(input int cq, input logic a_en, input logic a_up,
                                      input logic a_load, input int a_din);
        if (a_load) return (a_din > M - 1) ? M - 1 : a_din;
        if (a_en && a_up) return (cq + 1) % M;
        if (a_en) return (cq + M - 1) % M;
        return cq;
    endfunction

    // Drive one cycle (called just after a rising edge), push expectation,
    // sample combinational outputs before the edge, then cross the edge.
    task automatic apply(input logic a_en, input logic a_up, input logic a_load,
                         input logic [W-1:0] a_din);
        exp_t e;
        int   n;
        en = a_en; up = a_up; load = a_load; din = a_din;
        #1;
        n      = model_next(int'(m_q), a_en, a_up, a_load, int'(a_din));
        e.q    = W'(n);
        e.tc   = a_en && !a_load && (a_up ? (int'(m_q) == M - 1) : (m_q == 4'd0));
        e.wrap = e.tc;
        for (int b = 0; b < W; b++) begin
            e.j[b] = (m_q[b] == 1'b0) && (e.q[b] == 1'b1);
            e.k[b] = (m_q[b] == 1'b1) && (e.q[b] == 1'b0);
        end
        sb.push_back(e);
        obs_j  = j;
        obs_k  = k;
        obs_tc = tc;
        @(posedge clk);
        #1;
        m_q = e.q;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = 4'd0;
        m_q = 4'd0;
        #3;
        vectors += 5;
        if (q !== 4'd0)    begin miscompares++; $display("FAIL reset_q: got %0d expected 0", q); end
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
        if (j !== 4'd0)    begin miscompares++; $display("FAIL reset_j: got %b expected 0000", j); end
        if (k !== 4'd0)    begin miscompares++; $display("FAIL reset_k: got %b expected 0000", k); end
        if (tc !== 1'b0)   begin miscompares++; $display("FAIL reset_tc: got %0b expected 0", tc); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply(1'b0, 1'b1, 1'b1, 4'd7);
        e = sb.pop_front();
        vectors++;
        if (q !== e.q) begin miscompares++; $display("FAIL areset_pre_q: got %0d expected %0d", q, e.q); end
        #2;
        rst = 1'b0;
        #1;
        vectors += 2;
        if (q !== 4'd0)    begin miscompares++; $display("FAIL areset_q: got %0d expected 0", q); end
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL areset_wrap: got %0b expected 0", wrap); end
        en = 1'b1; up = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (q !== 4'd0) begin miscompares++; $display("FAIL areset_hold_q: got %0d expected 0", q); end
        rst = 1'b1; m_q = 4'd0;
        // Pending wrap discarded: wrap from 9, then reset before the next edge.
        apply(1'b0, 1'b1, 1'b1, 4'd9);
        void'(sb.pop_front());
        apply(1'b1, 1'b1, 1'b0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (wrap !== e.wrap) begin miscompares++; $display("FAIL areset_prewrap: got %0b expected %0b", wrap, e.wrap); end
        rst = 1'b0;
        #1;
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL areset_wrap_drop: got %0b expected 0", wrap); end
        @(posedge clk); #1;
        rst = 1'b1; m_q = 4'd0;
    endtask

    task automatic test_up_wrap();
        exp_t e;
        int   wraps;
        wraps = 0;
        apply(1'b0, 1'b1, 1'b1, 4'd0);
        void'(sb.pop_front());
        for (int i = 1; i <= 20; i++) begin
            apply(1'b1, 1'b1, 1'b0, 4'd0);
            e = sb.pop_front();
            vectors += 3;
            if (q !== e.q)       begin miscompares++; $display("FAIL up_q[%0d]: got %0d expected %0d", i, q, e.q); end
            if (wrap !== e.wrap) begin miscompares++; $display("FAIL up_wrap[%0d]: got %0b expected %0b", i, wrap, e.wrap); end
            if (obs_tc !== e.tc) begin miscompares++; $display("FAIL up_tc[%0d]: got %0b expected %0b", i, obs_tc, e.tc); end
            if (wrap === 1'b1) wraps++;
            if (i == 9) begin
                #1;
                vectors += 2;
                if (q !== 4'd9) begin miscompares++; $display("FAIL up_q9: got %0d expected 9", q); end
                if (tc !== 1'b1) begin miscompares++; $display("FAIL up_tc9: got %0b expected 1", tc); end
            end
        end
        vectors++;
        if (wraps != 2) begin miscompares++; $display("FAIL up_wrap_count: got %0d expected 2", wraps); end
    endtask

    task automatic test_down_wrap();
        exp_t         e;
        logic [W-1:0] want[3];
        want[0] = 4'd9; want[1] = 4'd8; want[2] = 4'd7;
        apply(1'b0, 1'b1, 1'b1, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 4'd0);
            e = sb.pop_front();
            vectors += 3;
            if (q !== e.q)       begin miscompares++; $display("FAIL down_q[%0d]: got %0d expected %0d", i, q, e.q); end
            if (q !== want[i])   begin miscompares++; $display("FAIL down_const[%0d]: got %0d expected %0d", i, q, want[i]); end
            if (wrap !== e.wrap) begin miscompares++; $display("FAIL down_wrap[%0d]: got %0b expected %0b", i, wrap, e.wrap); end
        end
    endtask

    task automatic test_load_clamp();
        exp_t e;
        apply(1'b1, 1'b1, 1'b1, 4'd5);
        e = sb.pop_front();
        vectors += 2;
        if (q !== 4'd5 || q !== e.q) begin miscompares++; $display("FAIL load5_q: got %0d expected 5", q); end
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL load5_wrap: got %0b expected 0", wrap); end
        apply(1'b0, 1'b1, 1'b1, 4'd12);
        e = sb.pop_front();
        vectors++;
        if (q !== 4'd9 || q !== e.q) begin miscompares++; $display("FAIL clamp12_q: got %0d expected 9", q); end
        apply(1'b1, 1'b1, 1'b1, 4'd3);
        e = sb.pop_front();
        vectors += 3;
        if (obs_tc !== 1'b0) begin miscompares++; $display("FAIL loadtc_tc: got %0b expected 0", obs_tc); end
        if (q !== 4'd3 || q !== e.q) begin miscompares++; $display("FAIL loadtc_q: got %0d expected 3", q); end
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL loadtc_wrap: got %0b expected 0", wrap); end
    endtask

    task automatic test_hold();
        exp_t e;
        apply(1'b0, 1'b1, 1'b1, 4'd6);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, i[0], 1'b0, 4'd0);
            e = sb.pop_front();
            vectors += 4;
            if (q !== 4'd6 || q !== e.q) begin miscompares++; $display("FAIL hold_q[%0d]: got %0d expected 6", i, q); end
            if (obs_j !== 4'b0000) begin miscompares++; $display("FAIL hold_j[%0d]: got %b expected 0000", i, obs_j); end
            if (obs_k !== 4'b0000) begin miscompares++; $display("FAIL hold_k[%0d]: got %b expected 0000", i, obs_k); end
            if (obs_tc !== 1'b0)   begin miscompares++; $display("FAIL hold_tc[%0d]: got %0b expected 0", i, obs_tc); end
        end
    endtask

    task automatic test_excitation();
        exp_t e;
        apply(1'b0, 1'b1, 1'b1, 4'd7);
        void'(sb.pop_front());
        apply(1'b1, 1'b1, 1'b0, 4'd0);
        e = sb.pop_front();
        vectors += 3;
        if (obs_j !== 4'b1000 || obs_j !== e.j) begin miscompares++; $display("FAIL exc_up_j: got %b expected 1000", obs_j); end
        if (obs_k !== 4'b0111 || obs_k !== e.k) begin miscompares++; $display("FAIL exc_up_k: got %b expected 0111", obs_k); end
        if (q !== 4'd8) begin miscompares++; $display("FAIL exc_up_q: got %0d expected 8", q); end
        apply(1'b1, 1'b0, 1'b0, 4'd0);
        e = sb.pop_front();
        vectors += 3;
        if (obs_j !== 4'b0111 || obs_j !== e.j) begin miscompares++; $display("FAIL exc_dn_j: got %b expected 0111", obs_j); end
        if (obs_k !== 4'b1000 || obs_k !== e.k) begin miscompares++; $display("FAIL exc_dn_k: got %b expected 1000", obs_k); end
        if (q !== 4'd7) begin miscompares++; $display("FAIL exc_dn_q: got %0d expected 7", q); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            e = sb.pop_front();
            vectors += 5;
            if (q !== e.q)       begin miscompares++; $display("FAIL b2b_q[%0d]: got %0d expected %0d", i, q, e.q); end
            if (wrap !== e.wrap) begin miscompares++; $display("FAIL b2b_wrap[%0d]: got %0b expected %0b", i, wrap, e.wrap); end
            if (obs_j !== e.j)   begin miscompares++; $display("FAIL b2b_j[%0d]: got %b expected %b", i, obs_j, e.j); end
            if (obs_k !== e.k)   begin miscompares++; $display("FAIL b2b_k[%0d]: got %b expected %b", i, obs_k, e.k); end
            if (obs_tc !== e.tc) begin miscompares++; $display("FAIL b2b_tc[%0d]: got %0b expected %0b", i, obs_tc, e.tc); end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_hold();
        test_excitation();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_jk_sync_counter
